// File: rtl/alu_decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_decode_stage_pkg
//
// Purpose: shared definitions for the ALU decode stage. The `define block
// holds the processor_defines ALU opcode codes that the ALU itself consumes
// (including the reserved `ALU_NOP, which the ALU treats as "do nothing,
// do not write rd"). The package holds the RV32I opcode and funct7
// constants, the decoded-bundle struct and a small shamt helper.
//
// Ports: none (package only).
// Optional feature macro used elsewhere in this slice: ILLEGAL_COUNT_EN.
// ---------------------------------------------------------------------------
`ifndef ALU_DECODE_STAGE_PROCESSOR_DEFINES
`define ALU_DECODE_STAGE_PROCESSOR_DEFINES
`define ADD     5'h00
`define SUB     5'h01
`define SLL     5'h02
`define SLT     5'h03
`define SLTU    5'h04
`define XOR     5'h05
`define SRL     5'h06
`define SRA     5'h07
`define OR      5'h08
`define AND     5'h09
`define ADDI    5'h0A
`define SLTI    5'h0B
`define SLTIU   5'h0C
`define XORI    5'h0D
`define ORI     5'h0E
`define ANDI    5'h0F
`define SLLI    5'h10
`define SRLI    5'h11
`define SRAI    5'h12
`define LUI     5'h13
`define AUIPC   5'h14
`define ALU_NOP 5'h1F
`endif

package alu_decode_stage_pkg;

  // Major opcodes this stage understands; everything else is illegal.
  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  // funct7 values: the base encoding and the "alternate" one that selects
  // SUB / SRA / SRAI.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Everything the downstream register-read / ALU stage needs for one
  // instruction, kept together so the output register and skid entry move
  // as a single unit.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  aluControl;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic        illegal;
  } decode_bundle_t;

  // The ALU expects the shift amount with its bit order reversed
  // (result[0] = shamt[4] ... result[4] = shamt[0]).
  function automatic logic [4:0] reverseShamt(input logic [4:0] shamt);
    logic [4:0] result;
    for (int i = 0; i < 5; i++) begin
      result[i] = shamt[4 - i];
    end
    return result;
  endfunction

endpackage

// File: rtl/alu_decode_stage_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
//
// Purpose: purely combinational RV32I instruction -> ALU control bundle
// decode for the OP, OP-IMM, LUI and AUIPC opcodes. Anything it does not
// recognise is flagged illegal and given `ALU_NOP so the ALU leaves rd alone;
// register fields are still passed through in that case.
//
// Ports:
//   i_instr       in  32  instruction word
//   o_aluControl  out  5  ALU opcode (processor_defines code)
//   o_imm         out 32  decoded immediate
//   o_rs1Addr     out  5  rs1 index (0 for LUI/AUIPC)
//   o_rs2Addr     out  5  rs2 index (0 for I-type, LUI, AUIPC)
//   o_rdAddr      out  5  rd index
//   o_illegal     out  1  instruction not decodable
// ---------------------------------------------------------------------------
module alu_decoder
  import alu_decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_aluControl,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1Addr,
  output logic [4:0]  o_rs2Addr,
  output logic [4:0]  o_rdAddr,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // Start from "illegal, pass the register fields through" and let each
  // recognised encoding clear the illegal flag and fill in its own fields.
  // OP-IMM always zeroes rs2, even when the funct7 of a shift is bad, since
  // bits [24:20] are a shift amount rather than a register there.
  always_comb begin
    o_aluControl = `ALU_NOP;
    o_imm        = '0;
    o_rs1Addr    = i_instr[19:15];
    o_rs2Addr    = i_instr[24:20];
    o_rdAddr     = i_instr[11:7];
    o_illegal    = 1'b1;

    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == F7_BASE) begin
          o_illegal = 1'b0;
          case (w_funct3)
            3'b000: o_aluControl = `ADD;
            3'b001: o_aluControl = `SLL;
            3'b010: o_aluControl = `SLT;
            3'b011: o_aluControl = `SLTU;
            3'b100: o_aluControl = `XOR;
            3'b101: o_aluControl = `SRL;
            3'b110: o_aluControl = `OR;
            3'b111: o_aluControl = `AND;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          o_illegal    = 1'b0;
          o_aluControl = `SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          o_illegal    = 1'b0;
          o_aluControl = `SRA;
        end
      end

      OPC_OP_IMM: begin
        o_rs2Addr = '0;
        o_imm     = {{20{i_instr[31]}}, i_instr[31:20]};
        case (w_funct3)
          3'b000: begin o_illegal = 1'b0; o_aluControl = `ADDI;  end
          3'b010: begin o_illegal = 1'b0; o_aluControl = `SLTI;  end
          3'b011: begin o_illegal = 1'b0; o_aluControl = `SLTIU; end
          3'b100: begin o_illegal = 1'b0; o_aluControl = `XORI;  end
          3'b110: begin o_illegal = 1'b0; o_aluControl = `ORI;   end
          3'b111: begin o_illegal = 1'b0; o_aluControl = `ANDI;  end
          3'b001: begin
            o_imm = {27'd0, reverseShamt(i_instr[24:20])};
            if (w_funct7 == F7_BASE) begin
              o_illegal    = 1'b0;
              o_aluControl = `SLLI;
            end
          end
          3'b101: begin
            o_imm = {27'd0, reverseShamt(i_instr[24:20])};
            if (w_funct7 == F7_BASE) begin
              o_illegal    = 1'b0;
              o_aluControl = `SRLI;
            end else if (w_funct7 == F7_ALT) begin
              o_illegal    = 1'b0;
              o_aluControl = `SRAI;
            end
          end
        endcase
      end

      OPC_LUI: begin
        o_illegal    = 1'b0;
        o_aluControl = `LUI;
        o_imm        = {i_instr[31:12], 12'h000};
        o_rs1Addr    = '0;
        o_rs2Addr    = '0;
      end

      OPC_AUIPC: begin
        o_illegal    = 1'b0;
        o_aluControl = `AUIPC;
        o_imm        = {i_instr[31:12], 12'h000};
        o_rs1Addr    = '0;
        o_rs2Addr    = '0;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//
// Purpose: decode stage between fetch and register-read/ALU. Takes an
// instruction word + PC over valid/ready, decodes it with alu_decoder and
// presents the bundle from a registered output with a one-entry skid buffer,
// so in_ready can be a register and throughput stays at one per cycle.
//
// Ports:
//   clk, rst (sync, active high), flush (drop everything held)
//   in_valid / in_ready / in_instr[31:0] / in_pc[31:0]      upstream side
//   out_valid / out_ready / out_pc / out_imm / out_alu_control
//   out_rs1_addr / out_rs2_addr / out_rd_addr / out_illegal  downstream side
//   illegal_count[CNT_W-1:0]  only when ILLEGAL_COUNT_EN is defined:
//                             saturating count of illegal bundles handed
//                             downstream; cleared by rst only.
//
// Configuration macro: ILLEGAL_COUNT_EN (undefined by default).
// ---------------------------------------------------------------------------
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [4:0]  out_alu_control,
  output logic [4:0]  out_rs1_addr,
  output logic [4:0]  out_rs2_addr,
  output logic [4:0]  out_rd_addr,
  output logic        out_illegal
`ifdef ILLEGAL_COUNT_EN
  ,
  output logic [CNT_W-1:0] illegal_count
`endif
);

  if (CNT_W < 1) begin : g_cntWidthCheck
    $error("alu_decode_stage: CNT_W must be at least 1");
  end

  logic [4:0]     w_aluControl;
  logic [31:0]    w_imm;
  logic [4:0]     w_rs1Addr;
  logic [4:0]     w_rs2Addr;
  logic [4:0]     w_rdAddr;
  logic           w_illegal;
  decode_bundle_t w_decoded;
  logic           w_accept;
  logic           w_transfer;

  decode_bundle_t r_out;
  decode_bundle_t r_skid;
  logic           r_outValid;
  logic           r_skidValid;
  logic           r_inReady;

  alu_decoder u_decoder (
    .i_instr      (in_instr),
    .o_aluControl (w_aluControl),
    .o_imm        (w_imm),
    .o_rs1Addr    (w_rs1Addr),
    .o_rs2Addr    (w_rs2Addr),
    .o_rdAddr     (w_rdAddr),
    .o_illegal    (w_illegal)
  );

  assign w_decoded = '{
    pc:         in_pc,
    imm:        w_imm,
    aluControl: w_aluControl,
    rs1Addr:    w_rs1Addr,
    rs2Addr:    w_rs2Addr,
    rdAddr:     w_rdAddr,
    illegal:    w_illegal
  };

  // r_inReady is only ever 1 while the skid entry is empty, so an accepted
  // word always has somewhere to go. Flush priority is handled in the
  // sequential block rather than here.
  assign w_accept   = in_valid && r_inReady;
  assign w_transfer = r_outValid && out_ready;

  // Output register + skid buffer. When the output slot is free (empty or
  // draining this cycle) it is refilled from the skid first, otherwise from
  // the decoder, which keeps program order. When the output is stalled a new
  // word parks in the skid and in_ready drops for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
    end else if (!r_outValid || w_transfer) begin
      r_inReady <= 1'b1;
      if (r_skidValid) begin
        r_out       <= r_skid;
        r_outValid  <= 1'b1;
        r_skidValid <= 1'b0;
      end else begin
        r_outValid <= w_accept;
        if (w_accept) begin
          r_out <= w_decoded;
        end
      end
    end else if (w_accept) begin
      r_skid      <= w_decoded;
      r_skidValid <= 1'b1;
      r_inReady   <= 1'b0;
    end else begin
      r_inReady <= !r_skidValid;
    end
  end

  assign in_ready        = r_inReady;
  assign out_valid       = r_outValid;
  assign out_pc          = r_out.pc;
  assign out_imm         = r_out.imm;
  assign out_alu_control = r_out.aluControl;
  assign out_rs1_addr    = r_out.rs1Addr;
  assign out_rs2_addr    = r_out.rs2Addr;
  assign out_rd_addr     = r_out.rdAddr;
  assign out_illegal     = r_out.illegal;

`ifdef ILLEGAL_COUNT_EN
  logic [CNT_W-1:0] r_illegalCount;

  // Counts illegal bundles actually handed downstream, including one that
  // leaves in the same cycle as a flush. Sticks at all-ones; only rst clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegalCount <= '0;
    end else if (w_transfer && r_out.illegal && (r_illegalCount != '1)) begin
      r_illegalCount <= r_illegalCount + CNT_W'(1);
    end
  end

  assign illegal_count = r_illegalCount;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Self-checking bench for alu_decode_stage. A behavioural model keeps the
// held bundles in a queue (at most two: output + skid) and decodes words
// from the RV32I field rules; every cycle the DUT outputs are compared
// against the queue head. Directed steps cover the named instructions,
// back-pressure and flush; a random phase follows.
// Honors ILLEGAL_COUNT_EN when defined.
// ---------------------------------------------------------------------------
module tb_alu_decode_stage;

  localparam logic [4:0] C_ADD = 5'h00, C_SUB = 5'h01, C_SLL = 5'h02, C_SLT = 5'h03;
  localparam logic [4:0] C_SLTU = 5'h04, C_XOR = 5'h05, C_SRL = 5'h06, C_SRA = 5'h07;
  localparam logic [4:0] C_OR = 5'h08, C_AND = 5'h09, C_ADDI = 5'h0A, C_SLTI = 5'h0B;
  localparam logic [4:0] C_SLTIU = 5'h0C, C_XORI = 5'h0D, C_ORI = 5'h0E, C_ANDI = 5'h0F;
  localparam logic [4:0] C_SLLI = 5'h10, C_SRLI = 5'h11, C_SRAI = 5'h12, C_LUI = 5'h13;
  localparam logic [4:0] C_AUIPC = 5'h14, C_NOP = 5'h1F;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_alu_control, out_rs1_addr, out_rs2_addr, out_rd_addr;
`ifdef ILLEGAL_COUNT_EN
  logic [15:0] illegal_count;
`endif

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_alu_control(out_alu_control), .out_rs1_addr(out_rs1_addr),
    .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
`ifdef ILLEGAL_COUNT_EN
    , .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  bit   mReady = 1'b0;
  int   mCount = 0;
  bit   lastAccepted = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference decode written from the instruction-set rules.
  function automatic exp_t refDecode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.imm = 32'd0; e.illegal = 1'b1; e.alu = C_NOP;
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin
        e.illegal = 1'b0;
        case (f3)
          3'd0: e.alu = C_ADD;  3'd1: e.alu = C_SLL; 3'd2: e.alu = C_SLT; 3'd3: e.alu = C_SLTU;
          3'd4: e.alu = C_XOR;  3'd5: e.alu = C_SRL; 3'd6: e.alu = C_OR;  default: e.alu = C_AND;
        endcase
      end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
        e.illegal = 1'b0;
        e.alu = (f3 == 3'd0) ? C_SUB : C_SRA;
      end
    end else if (op == 7'h13) begin
      e.rs2 = 5'd0;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        for (int i = 0; i < 5; i++) e.imm[i] = ins[24 - i];
        if (f3 == 3'd1 && f7 == 7'h00) begin e.illegal = 1'b0; e.alu = C_SLLI; end
        if (f3 == 3'd5 && f7 == 7'h00) begin e.illegal = 1'b0; e.alu = C_SRLI; end
        if (f3 == 3'd5 && f7 == 7'h20) begin e.illegal = 1'b0; e.alu = C_SRAI; end
      end else begin
        e.imm = $unsigned($signed(ins) >>> 20);
        e.illegal = 1'b0;
        case (f3)
          3'd0: e.alu = C_ADDI; 3'd2: e.alu = C_SLTI; 3'd3: e.alu = C_SLTIU;
          3'd4: e.alu = C_XORI; 3'd6: e.alu = C_ORI;  default: e.alu = C_ANDI;
        endcase
      end
    end else if (op == 7'h37 || op == 7'h17) begin
      e.illegal = 1'b0;
      e.alu = (op == 7'h37) ? C_LUI : C_AUIPC;
      e.imm = ins & 32'hFFFF_F000;
      e.rs1 = 5'd0; e.rs2 = 5'd0;
    end
    return e;
  endfunction

  function automatic logic [6:0] pickF7();
    int r = $urandom_range(0, 3);
    if (r < 2) return 7'h00;
    if (r == 2) return 7'h20;
    return 7'($urandom());
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w = $urandom();
    case ($urandom_range(0, 6))
      0: begin w[6:0] = 7'h33; w[31:25] = pickF7(); end
      1, 2: begin w[6:0] = 7'h13; if (w[13:12] == 2'b01) w[31:25] = pickF7(); end
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      5: ;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready", 32'(in_ready), 32'(mReady));
    checkOutput("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("out_pc", out_pc, q[0].pc);
      checkOutput("out_imm", out_imm, q[0].imm);
      checkOutput("out_alu_control", 32'(out_alu_control), 32'(q[0].alu));
      checkOutput("out_rs1_addr", 32'(out_rs1_addr), 32'(q[0].rs1));
      checkOutput("out_rs2_addr", 32'(out_rs2_addr), 32'(q[0].rs2));
      checkOutput("out_rd_addr", 32'(out_rd_addr), 32'(q[0].rd));
      checkOutput("out_illegal", 32'(out_illegal), 32'(q[0].illegal));
    end
`ifdef ILLEGAL_COUNT_EN
    checkOutput("illegal_count", 32'(illegal_count), mCount);
`endif
  endtask

  // Drive one cycle (called just after a negedge), advance the model over
  // the coming posedge, then check at the following negedge.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                               input bit rdy, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    lastAccepted = v && mReady && !fl;
    if (q.size() > 0 && rdy) begin
      if (q[0].illegal && mCount != 16'hFFFF) mCount++;
      void'(q.pop_front());
    end
    if (fl) q.delete();
    else if (lastAccepted) q.push_back(refDecode(ins, pc));
    mReady = (q.size() < 2);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] b2b[4];
    logic [31:0] seen[$];
    int idx;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll();
    checkOutput("reset out_pc", out_pc, 32'd0);
    checkOutput("reset out_imm", out_imm, 32'd0);
    checkOutput("reset out_alu_control", 32'(out_alu_control), 32'd0);
    rst = 1'b0;
    applyStimulus(0, 32'd0, 32'd0, 1, 0);
    checkOutput("ready after reset", 32'(in_ready), 32'd1);

    applyStimulus(1, 32'hFFF10093, 32'h100, 1, 0);
    checkOutput("addi valid", 32'(out_valid), 32'd1);
    checkOutput("addi alu", 32'(out_alu_control), 32'(C_ADDI));
    checkOutput("addi imm", out_imm, 32'hFFFF_FFFF);
    checkOutput("addi rs1", 32'(out_rs1_addr), 32'd2);
    checkOutput("addi rd", 32'(out_rd_addr), 32'd1);
    checkOutput("addi pc", out_pc, 32'h100);
    checkOutput("addi illegal", 32'(out_illegal), 32'd0);

    applyStimulus(1, 32'h40525193, 32'h104, 1, 0);
    checkOutput("srai alu", 32'(out_alu_control), 32'(C_SRAI));
    checkOutput("srai imm", out_imm, 32'h0000_0014);
    checkOutput("srai rs1", 32'(out_rs1_addr), 32'd4);
    checkOutput("srai rd", 32'(out_rd_addr), 32'd3);

    applyStimulus(1, 32'h123452B7, 32'h108, 1, 0);
    checkOutput("lui alu", 32'(out_alu_control), 32'(C_LUI));
    checkOutput("lui imm", out_imm, 32'h1234_5000);
    checkOutput("lui rs1", 32'(out_rs1_addr), 32'd0);
    checkOutput("lui rd", 32'(out_rd_addr), 32'd5);

    applyStimulus(1, 32'h00000000, 32'h10C, 1, 0);
    checkOutput("zero illegal", 32'(out_illegal), 32'd1);
    checkOutput("zero alu", 32'(out_alu_control), 32'(C_NOP));
    applyStimulus(0, 32'd0, 32'd0, 1, 0);
`ifdef ILLEGAL_COUNT_EN
    checkOutput("count after illegal", 32'(illegal_count), 32'd1);
`endif

    // Back-to-back stream of four with the output stalled for three cycles.
    b2b[0] = 32'h002081B3; b2b[1] = 32'h40418233; b2b[2] = 32'h0062F2B3; b2b[3] = 32'h00735313;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && c >= 3) seen.push_back(out_pc);
      applyStimulus(idx < 4, b2b[idx % 4], 32'h200 + 32'(idx * 4), c >= 3, 0);
      if (lastAccepted) idx++;
      if (c == 2) begin
        checkOutput("b2b accepted while stalled", 32'(idx), 32'd2);
        checkOutput("b2b in_ready stalled", 32'(in_ready), 32'd0);
      end
    end
    checkOutput("b2b emerged", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      checkOutput("b2b order", seen[i], 32'h200 + 32'(i * 4));

    // Flush with output and skid both full, and a word offered alongside.
    applyStimulus(1, 32'h00100093, 32'h300, 0, 0);
    applyStimulus(1, 32'h00200113, 32'h304, 0, 0);
    checkOutput("flush prep full", 32'(in_ready), 32'd0);
    applyStimulus(1, 32'h00300193, 32'h308, 0, 1);
    checkOutput("flush out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 32'd0, 32'd0, 1, 0);
      checkOutput("flushed stays gone", 32'(out_valid), 32'd0);
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom() & 32'hFFFF_FFFC,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end
    for (int c = 0; c < 4; c++) applyStimulus(0, 32'd0, 32'd0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
